// File: rtl/serial_alu_sequencer_if.sv
// Request/status bus plus the bit-serial link to the external 1-bit ALU slice.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [2:0]       Mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic [2:0]       ALU_Mode;
    logic             ALU_A;
    logic             ALU_B;
    logic             ALU_C_in;
    logic             ALU_X;
    logic             ALU_C_out;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Zero;
    logic             Err;

    modport slave (
        input  Start, Mode, A, B, C_in, ALU_X, ALU_C_out,
        output ALU_Mode, ALU_A, ALU_B, ALU_C_in, Busy, Done, Result, Carry, Zero, Err
    );

    modport master (
        output Start, Mode, A, B, C_in, ALU_X, ALU_C_out,
        input  ALU_Mode, ALU_A, ALU_B, ALU_C_in, Busy, Done, Result, Carry, Zero, Err
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Sequences a WIDTH-bit operation LSB-first through an external 1-bit ALU slice.
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic CLK,
    input  logic RST,
    serial_alu_sequencer_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_XNOR = 3'd4;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       mode_q;
    logic             carry_q;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] result_q;
    logic             carry_flag;
    logic             zero_flag;
    logic             err_flag;

    logic             is_add;
    logic             illegal;
    logic [WIDTH-1:0] next_sr;

    always_comb begin
        is_add  = (mode_q == OP_ADD);
        illegal = (mode_q > OP_XNOR);
        next_sr = {bus.ALU_X, sr[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= '0;
            carry_q    <= 1'b0;
            sr         <= '0;
            result_q   <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        mode_q  <= bus.Mode;
                        carry_q <= (bus.Mode == OP_ADD) ? bus.C_in : 1'b0;
                        idx     <= '0;
                        sr      <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sr      <= next_sr;
                    carry_q <= is_add ? bus.ALU_C_out : 1'b0;
                    if (idx == LAST) begin
                        // Flags are captured from the final slice output in the same edge.
                        state      <= S_DONE;
                        result_q   <= illegal ? '0 : next_sr;
                        carry_flag <= is_add ? bus.ALU_C_out : 1'b0;
                        zero_flag  <= illegal ? 1'b1 : (next_sr == '0);
                        err_flag   <= illegal;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ALU_Mode = mode_q;
        bus.ALU_A    = (state == S_RUN) ? a_q[idx] : 1'b0;
        bus.ALU_B    = (state == S_RUN) ? b_q[idx] : 1'b0;
        bus.ALU_C_in = (state == S_RUN && is_add) ? carry_q : 1'b0;
        bus.Busy     = (state == S_RUN);
        bus.Done     = (state == S_DONE);
        bus.Result   = result_q;
        bus.Carry    = carry_flag;
        bus.Zero     = zero_flag;
        bus.Err      = err_flag;
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench: behavioural 1-bit slice model, hand-computed vectors for each opcode.
module tb_serial_alu_sequencer;
    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Downstream slice: combinational in the ALU_* outputs.
    always_comb begin
        bus.ALU_X     = 1'b0;
        bus.ALU_C_out = 1'b0;
        case (bus.ALU_Mode)
            3'd0: begin
                bus.ALU_X     = bus.ALU_A ^ bus.ALU_B ^ bus.ALU_C_in;
                bus.ALU_C_out = (bus.ALU_A & bus.ALU_B) | (bus.ALU_C_in & (bus.ALU_A ^ bus.ALU_B));
            end
            3'd1: bus.ALU_X = bus.ALU_A & bus.ALU_B;
            3'd2: bus.ALU_X = bus.ALU_A | bus.ALU_B;
            3'd3: bus.ALU_X = bus.ALU_A ^ bus.ALU_B;
            3'd4: bus.ALU_X = ~(bus.ALU_A ^ bus.ALU_B);
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic launch(input logic [2:0] mode, input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Mode  = mode;
        bus.A     = a;
        bus.B     = b;
        bus.C_in  = cin;
        @(posedge CLK);
        #1 bus.Start = 1'b0;
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge that raised Done.
    task automatic wait_done(input int inject_at, output int edges, output int busy_cnt,
                             output logic cin_seen);
        edges    = 0;
        busy_cnt = 0;
        cin_seen = 1'b0;
        while (!bus.Done && edges < 20) begin
            if (bus.Busy) busy_cnt++;
            if (bus.ALU_C_in) cin_seen = 1'b1;
            if (edges == inject_at) begin
                bus.Start = 1'b1;
                bus.Mode  = 3'd0;
                bus.A     = 8'hFF;
                bus.B     = 8'hFF;
                bus.C_in  = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge CLK);
            #1 edges++;
        end
        bus.Start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] mode, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [7:0] exp_res,
                          input logic exp_c, input logic exp_z, input logic exp_e,
                          input int inject_at);
        int   edges;
        int   busy_cnt;
        logic cin_seen;
        launch(mode, a, b, cin);
        wait_done(inject_at, edges, busy_cnt, cin_seen);
        check({tag, "_done_edges"}, 32'(edges), 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({tag, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
        check({tag, "_result"}, 32'(bus.Result), 32'(exp_res));
        check({tag, "_carry"}, 32'(bus.Carry), 32'(exp_c));
        check({tag, "_zero"}, 32'(bus.Zero), 32'(exp_z));
        check({tag, "_err"}, 32'(bus.Err), 32'(exp_e));
        if (mode != 3'd0) check({tag, "_alu_cin_seen"}, 32'(cin_seen), 32'd0);
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        check({tag, "_result_held"}, 32'(bus.Result), 32'(exp_res));
    endtask

    initial begin
        int   edges;
        int   busy_cnt;
        logic cin_seen;
        int   done_seen;

        bus.Start = 1'b0;
        bus.Mode  = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C_in  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_result", 32'(bus.Result), 32'd0);
        check("rst_flags", {29'd0, bus.Carry, bus.Zero, bus.Err}, 32'd0);
        check("rst_alu_mode", 32'(bus.ALU_Mode), 32'd0);
        check("rst_alu_ab", {30'd0, bus.ALU_A, bus.ALU_B}, 32'd0);

        // Reset overrides a simultaneous Start.
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Mode  = 3'd1;
        bus.A     = 8'hFF;
        bus.B     = 8'hFF;
        @(posedge CLK);
        #1;
        check("rst_over_start", 32'(bus.Busy), 32'd0);
        bus.Start = 1'b0;
        RST       = 1'b0;
        @(posedge CLK);
        #1;

        run_op("add_5a_3c", 3'd0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, -1);
        run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, -1);
        run_op("add_cin",   3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, -1);
        run_op("and",       3'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, -1);
        run_op("or",        3'd2, 8'hF0, 8'h0C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, -1);
        run_op("xor",       3'd3, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        run_op("xnor",      3'd4, 8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        run_op("illegal6",  3'd6, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, -1);
        run_op("add_clr_err", 3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, -1);
        // Start pulsed at RUN index 3 with other operands must be ignored.
        run_op("xor_inject", 3'd3, 8'h0F, 8'h33, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 3);

        // Start held through the DONE cycle: accepted only after one IDLE cycle.
        launch(3'd2, 8'h81, 8'h18, 1'b0);
        wait_done(-1, edges, busy_cnt, cin_seen);
        bus.Start = 1'b1;
        bus.Mode  = 3'd1;
        bus.A     = 8'hC3;
        bus.B     = 8'h0F;
        @(posedge CLK);
        #1;
        check("b2b_idle_gap", 32'(bus.Busy), 32'd0);
        @(posedge CLK);
        #1 bus.Start = 1'b0;
        check("b2b_accept", 32'(bus.Busy), 32'd1);
        wait_done(-1, edges, busy_cnt, cin_seen);
        check("b2b_result", 32'(bus.Result), 32'h03);
        @(posedge CLK);
        #1;

        // Reset at RUN index 4 aborts with no Done; previous Result is non-zero.
        launch(3'd0, 8'h01, 8'h01, 1'b0);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_result", 32'(bus.Result), 32'd0);
        check("abort_mode", 32'(bus.ALU_Mode), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Done || bus.Busy) done_seen++;
            @(posedge CLK);
            #1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op("add_after_rst", 3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end
endmodule
